// File: rtl/stdlib_pkg.sv
// Shared constants, beat payload type and count-width helper for the
// stdlib queue blocks.
//   WIDTH    : data width of one beat
//   TAG_W    : source tag width
//   NUM_TAGS : number of distinct source tags
//   cnt_w(d) : width needed to hold 0..d
`timescale 1ns/1ps
package stdlib_pkg;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned TAG_W    = 2;
    localparam int unsigned NUM_TAGS = 2 ** TAG_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] bits;
    } tagged_beat_t;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stdlib_tagged_queue_if.sv
// Enqueue/dequeue ready-valid bundle for stdlib_tagged_queue.
//   slave  : queue side (accepts enq, presents deq)
//   master : environment side (offers enq, consumes deq)
`timescale 1ns/1ps
interface stdlib_tagged_queue_if import stdlib_pkg::*; ();

    logic             io_enq_valid;
    logic             io_enq_ready;
    logic [WIDTH-1:0] io_enq_bits;
    logic [TAG_W-1:0] io_enq_tag;
    logic             io_deq_valid;
    logic             io_deq_ready;
    logic [WIDTH-1:0] io_deq_bits;
    logic [TAG_W-1:0] io_deq_tag;

    modport slave (
        input  io_enq_valid, io_enq_bits, io_enq_tag, io_deq_ready,
        output io_enq_ready, io_deq_valid, io_deq_bits, io_deq_tag
    );

    modport master (
        output io_enq_valid, io_enq_bits, io_enq_tag, io_deq_ready,
        input  io_enq_ready, io_deq_valid, io_deq_bits, io_deq_tag
    );

endinterface

// File: rtl/stdlib_tag_counter.sv
// Up/down occupancy counter; inc and dec together leave the value unchanged.
//   clk, reset (async active-low), inc, dec, value (registered)
`timescale 1ns/1ps
module stdlib_tag_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (inc && !dec) begin
            value <= value + W'(1);
        end else if (dec && !inc) begin
            value <= value - W'(1);
        end
    end

endmodule

// File: rtl/stdlib_tagged_queue.sv
// Tagged circular FIFO downstream of the round-robin arbiter, with total and
// per-source occupancy counts.
//   clk, reset (async active-low)
//   q               : enq/deq ready-valid bundle (slave side)
//   io_count        : total occupancy
//   io_tag_count_n  : occupancy per source tag n = 0..3
// Optional macro STDLIB_QUEUE_FLOW_EN: an empty queue passes the enq beat
// straight to deq in the same cycle.
`timescale 1ns/1ps
module stdlib_tagged_queue import stdlib_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    stdlib_tagged_queue_if.slave        q,
    output logic [cnt_w(DEPTH)-1:0]     io_count,
    output logic [cnt_w(DEPTH)-1:0]     io_tag_count_0,
    output logic [cnt_w(DEPTH)-1:0]     io_tag_count_1,
    output logic [cnt_w(DEPTH)-1:0]     io_tag_count_2,
    output logic [cnt_w(DEPTH)-1:0]     io_tag_count_3
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    tagged_beat_t     mem [DEPTH];
    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic             maybe_full;

    logic             ptr_match_c;
    logic             empty_c;
    logic             full_c;
    logic             enq_fire_c;
    logic             deq_fire_c;
    logic             do_enq_c;
    logic             do_deq_c;
    tagged_beat_t     head_c;
    tagged_beat_t     enq_beat_c;
    logic [CNT_W-1:0] tag_cnt [NUM_TAGS];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full/empty from registers only, so enq_ready never depends on deq_ready
    assign ptr_match_c = (enq_ptr == deq_ptr);
    assign empty_c     = ptr_match_c && !maybe_full;
    assign full_c      = ptr_match_c && maybe_full;

    assign enq_beat_c.tag  = q.io_enq_tag;
    assign enq_beat_c.bits = q.io_enq_bits;

    assign q.io_enq_ready = !full_c;
    assign enq_fire_c     = q.io_enq_valid && !full_c;

`ifdef STDLIB_QUEUE_FLOW_EN
    // Empty queue forwards the offered beat; a taken bypass touches no state
    logic flow_c;
    assign flow_c         = empty_c && q.io_enq_valid;
    assign q.io_deq_valid = !empty_c || q.io_enq_valid;
    assign head_c         = empty_c ? enq_beat_c : mem[deq_ptr];
    assign deq_fire_c     = q.io_deq_valid && q.io_deq_ready;
    assign do_enq_c       = enq_fire_c && !(flow_c && q.io_deq_ready);
    assign do_deq_c       = deq_fire_c && !flow_c;
`else
    assign q.io_deq_valid = !empty_c;
    assign head_c         = mem[deq_ptr];
    assign deq_fire_c     = q.io_deq_valid && q.io_deq_ready;
    assign do_enq_c       = enq_fire_c;
    assign do_deq_c       = deq_fire_c;
`endif

    assign q.io_deq_bits = head_c.bits;
    assign q.io_deq_tag  = head_c.tag;

    // Data array is intentionally not reset
    always_ff @(posedge clk) begin
        if (do_enq_c) begin
            mem[enq_ptr] <= enq_beat_c;
        end
    end

    // Pointer and full/empty disambiguation state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq_c) begin
                enq_ptr <= ptr_next(enq_ptr);
            end
            if (do_deq_c) begin
                deq_ptr <= ptr_next(deq_ptr);
            end
            if (do_enq_c != do_deq_c) begin
                maybe_full <= do_enq_c;
            end
        end
    end

    // Total occupancy
    stdlib_tag_counter #(.W(CNT_W)) u_total_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (do_enq_c),
        .dec   (do_deq_c),
        .value (io_count)
    );

    // Per-source occupancy; same-tag enq+deq cancels inside the counter
    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag_cnt
        logic inc_c;
        logic dec_c;
        assign inc_c = do_enq_c && (q.io_enq_tag == TAG_W'(g));
        assign dec_c = do_deq_c && (head_c.tag == TAG_W'(g));

        stdlib_tag_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_c),
            .dec   (dec_c),
            .value (tag_cnt[g])
        );
    end

    assign io_tag_count_0 = tag_cnt[0];
    assign io_tag_count_1 = tag_cnt[1];
    assign io_tag_count_2 = tag_cnt[2];
    assign io_tag_count_3 = tag_cnt[3];

endmodule

// File: doc/stdlib_tagged_queue.md
# stdlib_tagged_queue

Tagged output buffer placed directly downstream of the 4-input round-robin arbiter. It captures each granted beat (`io_out_bits` plus `io_chosen` as a 2-bit source tag) into a circular FIFO and re-presents it on a decoupled dequeue port. It also keeps per-source occupancy counts, which upstream logic reads for back-pressure and fairness monitoring. Enqueue behaves as a standard consumer of the arbiter's ready/valid output, so the arbiter's `last_grant` update happens on the same fire.

## Interface
- `DEPTH`, 4: number of entries. Any value ≥ 2 is legal; no power-of-two requirement.
- `WIDTH`, 8: data width; matches the arbiter `bits` width.
- `TAG_W`, 2: tag width; supports `NUM_TAGS = 2**TAG_W` sources.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 = reset.
- `io_enq_valid`  in  1  beat offered; connects to arbiter `io_out_valid`.
- `io_enq_ready`  out  1  queue can accept; connects to arbiter `io_out_ready`.
- `io_enq_bits`  in  WIDTH  data.
- `io_enq_tag`  in  TAG_W  source id; connects to arbiter `io_chosen`.
- `io_deq_valid`  out  1  head entry valid.
- `io_deq_ready`  in  1  consumer accepts.
- `io_deq_bits`  out  WIDTH  head data.
- `io_deq_tag`  out  TAG_W  head tag.
- `io_count`  out  clog2(DEPTH+1)  total occupancy.
- `io_tag_count_<n>`  out  clog2(DEPTH+1)  occupancy for tag n, for n = 0..NUM_TAGS-1.

## Operation
- Storage: DEPTH × {tag, bits} array. `enq_ptr` and `deq_ptr` run 0..DEPTH-1 and wrap to 0 after DEPTH-1. A `maybe_full` flag separates full from empty.
- Derived flags:
  - empty = (`enq_ptr` == `deq_ptr`) & !`maybe_full`.
  - full = (`enq_ptr` == `deq_ptr`) & `maybe_full`.
- `io_enq_ready` = !full. It is never combinationally dependent on `io_deq_ready`; there is no pipe-through when full.
- `io_deq_valid` = !empty. `io_deq_bits` and `io_deq_tag` = entry at `deq_ptr`.
- Handshakes:
  - enq fire = `io_enq_valid` & `io_enq_ready`: write the entry at `enq_ptr`, then increment `enq_ptr`.
  - deq fire = `io_deq_valid` & `io_deq_ready`: increment `deq_ptr`.
  - `maybe_full` is set on enq-only fire and cleared on deq-only fire. It holds when both or neither fire.
- Counts: `io_count` is +1 on enq-only and −1 on deq-only. `io_tag_count_<n>` is +1 when enq fires with tag n and −1 when deq fires with head tag n. When both fire with the same tag, that count is unchanged.
- Invariants: the sum of the tag counts equals `io_count`, and `io_count` ≤ DEPTH.
- Reset:
  - Pointers, `maybe_full` and all counts go to 0.
  - `io_enq_ready` = 1, `io_deq_valid` = 0.
  - Data array is not reset; `io_deq_bits` and `io_deq_tag` are don't-care while empty.
  - Asserting reset mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Enqueue-to-dequeue latency is 1 cycle: an entry written at edge k is visible on deq after edge k. Flow mode changes this (see Configuration).
- Sustained throughput is 1 beat/cycle with simultaneous enq and deq fires, at any occupancy from 1 to DEPTH-1.
- Boundary cases:
  - Full with both sides offered: only deq fires. `io_enq_ready` rises in the cycle after the deq.
  - Empty with `io_deq_ready` = 1: nothing fires.
- All counts are registered and update on the fire edge.
- `io_enq_ready` is glitch-free: it is a function of registers only.

## Configuration
- Macro `STDLIB_QUEUE_FLOW_EN` is defined:
  - When empty and `io_enq_valid` = 1, `io_deq_valid` = 1 and `io_deq_bits`/`io_deq_tag` pass combinationally from the enq port.
  - If deq fires in that cycle, nothing is written, and pointers and counts are unchanged. If it does not fire, the beat is stored normally.
- Macro not defined: flow path absent; minimum latency is 1 cycle.

## Structure
- Shared package `stdlib_pkg` holds:
  - `WIDTH`, `TAG_W`, `NUM_TAGS` constants.
  - `tagged_beat_t` struct {tag, bits}.
  - `cnt_w(depth)` helper function, which returns clog2(depth+1).
- Sub-module `stdlib_tag_counter`: a saturating-free up/down counter with inc, dec, async active-low reset and value output. It is instantiated once per tag and once for `io_count`.

## Test plan
- Reset, then enqueue 0x11/tag1, 0x22/tag3, 0x33/tag1 with `io_deq_ready` = 0:
  - `io_count` = 3, `io_tag_count_1` = 2, `io_tag_count_3` = 1.
  - `io_deq_bits` = 0x11, `io_deq_tag` = 1.
- Fill DEPTH=4 with 0xA0..0xA3, then hold enq valid with deq ready = 1 for one cycle:
  - `io_enq_ready` = 0 in that cycle and only deq fires.
  - Next cycle: `io_count` = 3, `io_enq_ready` = 1.
- Stream 16 beats with both sides always ready (wraps the pointers 4 times):
  - Output order is identical to input order.
  - `io_count` stays at 1 in steady state.
- Simultaneous enq (tag2) and deq (head tag2) at occupancy 2: `io_tag_count_2` is unchanged and `io_count` stays at 2.
- Assert reset low asynchronously between edges with 3 entries held:
  - `io_deq_valid` = 0 and all counts = 0 before the next clock edge.
  - After release, `io_enq_ready` = 1.
- With `STDLIB_QUEUE_FLOW_EN`: empty queue, enq 0x5A/tag0 with deq ready:
  - `io_deq_valid` = 1 and `io_deq_bits` = 0x5A in the same cycle.
  - Afterwards `io_count` remains 0.
